// File: rtl/fbmem_target.sv
// fbmem_target: frame-buffer memory responder on the shared command bus.
// Serves burst reads (cmd 010) and burst writes (cmd 100) from an internal
// word array, bidding through the arbiter for every response.
// Optional feature macro: FBMEM_ERR_EN (out-of-range requests answered with cmd 110).
module fbmem_target #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
  parameter logic [3:0]  INIT_ID     = 4'h1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WDAT = 3'b001;
  localparam logic [2:0] CMD_RREQ = 3'b010;
  localparam logic [2:0] CMD_RDAT = 3'b011;
  localparam logic [2:0] CMD_WREQ = 3'b100;
  localparam logic [2:0] CMD_WACK = 3'b101;
`ifdef FBMEM_ERR_EN
  localparam logic [2:0]  CMD_ERR  = 3'b110;
  localparam logic [32:0] ADDR_TOP = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_BID,
    ST_RD_DATA,
    ST_WR_BID,
    ST_WR_ACK,
    ST_WR_DATA
`ifdef FBMEM_ERR_EN
    , ST_ERR
`endif
  } state_t;

  state_t          r_state, w_state_n;
  logic [AW-1:0]   r_idx, w_idx_n;
  logic [1:0]      r_len, w_len_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [1:0]      r_reqout, w_reqout_n;
  logic [3:0]      r_reqtar, w_reqtar_n;
  logic [2:0]      r_cmdout, w_cmdout_n;
  logic [1:0]      r_lenout, w_lenout_n;
  logic [31:0]     r_data, w_data_n;
  logic            r_busy, w_busy_n;
  logic            w_we;
  logic [AW-1:0]   w_req_idx;
  logic [CW-1:0]   w_beats;
  logic [31:0]     w_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];
`ifdef FBMEM_ERR_EN
  logic            r_err, w_err_n;
  logic [31:0]     r_addr, w_addr_n;
  logic            w_req_err;
`endif

  // Word index of the incoming request and beat count of the latched burst
  assign w_req_idx = AW'((addrdatain - ADDR_BASE) >> 2);
  assign w_beats   = CW'(1) << r_len;
  assign w_rdata   = r_mem[r_idx];

`ifdef FBMEM_ERR_EN
  // Request is out of range or its burst runs past the top word
  assign w_req_err = ({1'b0, addrdatain} < {1'b0, ADDR_BASE}) ||
                     ({1'b0, addrdatain} >= ADDR_TOP) ||
                     ((33'(w_req_idx) + 33'(CW'(1) << lenin)) > 33'(DEPTH_WORDS));
`endif

  // Next-state, burst bookkeeping and next registered bus outputs
  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_len_n    = r_len;
    w_cnt_n    = r_cnt;
    w_we       = 1'b0;
    w_reqout_n = 2'b00;
    w_reqtar_n = 4'h0;
    w_cmdout_n = CMD_IDLE;
    w_lenout_n = 2'b00;
    w_data_n   = 32'h0;
`ifdef FBMEM_ERR_EN
    w_err_n    = r_err;
    w_addr_n   = r_addr;
`endif

    case (r_state)
      ST_IDLE: begin
        if (selin && ((cmdin == CMD_RREQ) || (cmdin == CMD_WREQ))) begin
          w_state_n = (cmdin == CMD_RREQ) ? ST_RD_BID : ST_WR_BID;
          w_idx_n   = w_req_idx;
          w_len_n   = lenin;
          w_cnt_n   = '0;
`ifdef FBMEM_ERR_EN
          w_err_n   = w_req_err;
          w_addr_n  = addrdatain;
`endif
        end
      end
      ST_RD_BID: begin
        if (ackin) begin
          w_state_n = ST_RD_DATA;
`ifdef FBMEM_ERR_EN
          if (r_err) w_state_n = ST_ERR;
`endif
        end
      end
      ST_RD_DATA: begin
        if (r_cnt == w_beats) w_state_n = ST_IDLE;
      end
      ST_WR_BID: begin
        if (ackin) begin
          w_state_n = ST_WR_ACK;
`ifdef FBMEM_ERR_EN
          if (r_err) w_state_n = ST_ERR;
`endif
        end
      end
      ST_WR_ACK: begin
        w_state_n = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (selin && (cmdin == CMD_WDAT)) begin
          w_we    = 1'b1;
          w_idx_n = r_idx + AW'(1);
          w_cnt_n = r_cnt + CW'(1);
          if (r_cnt == (w_beats - CW'(1))) w_state_n = ST_IDLE;
        end
      end
`ifdef FBMEM_ERR_EN
      ST_ERR: begin
        w_state_n = ST_IDLE;
      end
`endif
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // Bus outputs follow the state being entered so they register with it
    case (w_state_n)
      ST_RD_BID, ST_WR_BID: begin
        w_reqout_n = 2'b11;
        w_reqtar_n = INIT_ID;
      end
      ST_RD_DATA: begin
        w_reqout_n = 2'b11;
        w_reqtar_n = INIT_ID;
        w_cmdout_n = CMD_RDAT;
        w_lenout_n = r_len;
        w_data_n   = w_rdata;
        w_idx_n    = r_idx + AW'(1);
        w_cnt_n    = r_cnt + CW'(1);
      end
      ST_WR_ACK: begin
        w_reqout_n = 2'b11;
        w_reqtar_n = INIT_ID;
        w_cmdout_n = CMD_WACK;
        w_lenout_n = r_len;
      end
`ifdef FBMEM_ERR_EN
      ST_ERR: begin
        w_reqout_n = 2'b11;
        w_reqtar_n = INIT_ID;
        w_cmdout_n = CMD_ERR;
        w_lenout_n = r_len;
        w_data_n   = r_addr;
      end
`endif
      default: begin
      end
    endcase

    w_busy_n = (w_state_n != ST_IDLE);
  end

  // State, burst context and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_len    <= 2'b00;
      r_cnt    <= '0;
      r_reqout <= 2'b00;
      r_reqtar <= 4'h0;
      r_cmdout <= CMD_IDLE;
      r_lenout <= 2'b00;
      r_data   <= 32'h0;
      r_busy   <= 1'b0;
`ifdef FBMEM_ERR_EN
      r_err    <= 1'b0;
      r_addr   <= 32'h0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      r_len    <= w_len_n;
      r_cnt    <= w_cnt_n;
      r_reqout <= w_reqout_n;
      r_reqtar <= w_reqtar_n;
      r_cmdout <= w_cmdout_n;
      r_lenout <= w_lenout_n;
      r_data   <= w_data_n;
      r_busy   <= w_busy_n;
`ifdef FBMEM_ERR_EN
      r_err    <= w_err_n;
      r_addr   <= w_addr_n;
`endif
    end
  end

  // Pixel word array, not reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_idx] <= addrdatain;
  end

  assign reqout      = r_reqout;
  assign reqtar      = r_reqtar;
  assign cmdout      = r_cmdout;
  assign lenout      = r_lenout;
  assign addrdataout = r_data;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fbmem_target.sv
// tb_fbmem_target: scoreboard bench for fbmem_target; read beats are
// predicted from a word model when each read request is issued.
module tb_fbmem_target;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        busy;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_len_q [$];
  logic [31:0] wd [8];
  logic [31:0] mon_e;
  logic [1:0]  mon_l;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fbmem_target #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_BASE   (BASE),
    .INIT_ID     (4'h1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .selin       (selin),
    .cmdin       (cmdin),
    .lenin       (lenin),
    .addrdatain  (addrdatain),
    .ackin       (ackin),
    .reqout      (reqout),
    .reqtar      (reqtar),
    .cmdout      (cmdout),
    .lenout      (lenout),
    .addrdataout (addrdataout),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every read-data beat is compared with the next prediction
  always @(negedge clk) begin
    if (cmdout == 3'b011) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rd_beat", 32'(cmdout), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = exp_len_q.pop_front();
        check_eq("rd_data", addrdataout, mon_e);
        check_eq("rd_lenout", 32'(lenout), 32'(mon_l));
        check_eq("rd_reqout", 32'(reqout), 32'd3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] cmd, input logic [31:0] addr, input logic [1:0] len);
    selin = 1'b1; cmdin = cmd; lenin = len; addrdatain = addr;
    tick();
    selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = 32'h0;
  endtask

  task automatic grant(input int dly);
    for (int i = 0; i < dly; i++) begin
      check_eq("bid_hold", 32'(reqout), 32'd3);
      check_eq("bid_tar", 32'(reqtar), 32'd1);
      check_eq("no_resp_before_gnt", 32'(cmdout), 32'd0);
      tick();
    end
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
  endtask

`ifdef FBMEM_ERR_EN
  function automatic bit req_err(input logic [31:0] addr, input logic [1:0] len);
    longint a;
    a = longint'(addr);
    return (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * longint'(DEPTH)) ||
           ((((a - longint'(BASE)) >> 2) + (longint'(1) << len)) > longint'(DEPTH));
  endfunction
`endif

  task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input int dly);
    int idx;
    int n;
    bit err;
    err = 1'b0;
`ifdef FBMEM_ERR_EN
    err = req_err(addr, len);
`endif
    n   = 1 << len;
    idx = int'(((addr - BASE) >> 2) & 32'(DEPTH - 1));
    if (!err) begin
      for (int b = 0; b < n; b++) begin
        exp_q.push_back(model[(idx + b) % DEPTH]);
        exp_len_q.push_back(len);
      end
    end
    send_req(3'b010, addr, len);
    check_eq("rd_bid_busy", 32'(busy), 32'd1);
    grant(dly);
    if (err) begin
      check_eq("err_cmd", 32'(cmdout), 32'd6);
      check_eq("err_addr", addrdataout, addr);
      tick();
      check_eq("err_one_cycle", 32'(cmdout), 32'd0);
    end else begin
      check_eq("rd_first_beat", 32'(cmdout), 32'd3);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input int dly,
                          input logic [31:0] d [8], input logic [7:0] stall);
    int idx;
    int n;
    n   = 1 << len;
    idx = int'(((addr - BASE) >> 2) & 32'(DEPTH - 1));
    send_req(3'b100, addr, len);
    grant(dly);
    check_eq("wr_ack", 32'(cmdout), 32'd5);
    check_eq("wr_ack_len", 32'(lenout), 32'(len));
    check_eq("wr_ack_tar", 32'(reqtar), 32'd1);
    tick();
    check_eq("wr_ack_one_cycle", 32'(cmdout), 32'd0);
    check_eq("wr_data_reqout", 32'(reqout), 32'd0);
    check_eq("wr_data_busy", 32'(busy), 32'd1);
    for (int b = 0; b < n; b++) begin
      if (stall[b]) begin
        tick();
        check_eq("wr_stall_busy", 32'(busy), 32'd1);
      end
      selin = 1'b1; cmdin = 3'b001; addrdatain = d[b];
      model[(idx + b) % DEPTH] = d[b];
      tick();
      selin = 1'b0; cmdin = 3'b000; addrdatain = 32'h0;
    end
    check_eq("wr_done_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64 && (busy || exp_q.size() != 0); i++) tick();
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; selin = 1'b0; cmdin = 3'b000; lenin = 2'b00;
    addrdatain = 32'h0; ackin = 1'b0;
    repeat (3) tick();
    check_eq("rst_reqout", 32'(reqout), 32'd0);
    check_eq("rst_reqtar", 32'(reqtar), 32'd0);
    check_eq("rst_cmdout", 32'(cmdout), 32'd0);
    check_eq("rst_lenout", 32'(lenout), 32'd0);
    check_eq("rst_data", addrdataout, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // Write four RGB words then read them back
    wd = '{32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'h00123456, 32'h0, 32'h0, 32'h0, 32'h0};
    do_write(32'h0000_1000, 2'b10, 2, wd, 8'h00);
    do_read(32'h0000_1000, 2'b10, 0);
    wait_idle("rd_basic");

    // Stalled two-beat write over a prefilled region; words 2 and 3 must survive
    wd = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'h0, 32'h0, 32'h0, 32'h0};
    do_write(32'h0000_1800, 2'b10, 0, wd, 8'h00);
    wd = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    do_write(32'h0000_1800, 2'b01, 1, wd, 8'h02);
    do_read(32'h0000_1800, 2'b10, 1);
    wait_idle("rd_stall");

    // Wrap from the top word to word 0
    wd = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    do_write(32'h0000_1FFC, 2'b00, 0, wd, 8'h00);
    do_read(32'h0000_1FFC, 2'b01, 0);
    wait_idle("rd_wrap");

    // Grant withheld for 5 cycles, then a request dropped mid-burst
    do_read(32'h0000_1000, 2'b10, 5);
    tick();
    selin = 1'b1; cmdin = 3'b010; lenin = 2'b11; addrdatain = 32'h0000_1004;
    tick();
    selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = 32'h0;
    wait_idle("rd_drop");
    for (int i = 0; i < 3; i++) begin
      check_eq("no_second_bid", 32'(reqout), 32'd0);
      tick();
    end

    // Reset in the middle of a read burst
    do_read(32'h0000_1000, 2'b10, 0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_reqout", 32'(reqout), 32'd0);
    check_eq("arst_reqtar", 32'(reqtar), 32'd0);
    check_eq("arst_cmdout", 32'(cmdout), 32'd0);
    check_eq("arst_lenout", 32'(lenout), 32'd0);
    check_eq("arst_data", addrdataout, 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    exp_len_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_reqout", 32'(reqout), 32'd0);
    do_read(32'h0000_1000, 2'b10, 1);
    wait_idle("rd_after_rst");

    // Address just below the base
    do_read(32'h0000_0FFC, 2'b00, 0);
    wait_idle("rd_low_addr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
